// File: rtl/an_rx_ook_dec.sv
// On-off-keyed UART-style receiver: hysteresis tone slicer feeding a majority-vote
// symbol decoder (start, 8 data bits LSB first, stop) clocked by level-sample strobes.
module an_rx_ook_dec #(
    parameter int          C_SYM_LVs = 5,
    parameter logic [11:0] C_TH_ON   = 12'h300,
    parameter logic [11:0] C_TH_OFF  = 12'h200
) (
    input  logic        CK_i,
    input  logic        XARST_i,
    input  logic [11:0] LVs_i,
    input  logic        DONE_i,
    output logic [7:0]  DATs_o,
    output logic        VALID_o,
    output logic        FERR_o,
    output logic        TONE_o,
    output logic        BUSY_o
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_OFF
    } state_t;

    localparam logic [3:0] SMP_LAST = 4'(C_SYM_LVs - 1);
    localparam logic [4:0] SYM_N    = 5'(C_SYM_LVs);

    state_t      state_q, state_d;
    logic [3:0]  smp_q, smp_d;
    logic [3:0]  ones_q, ones_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic [7:0]  shreg_q, shreg_d;
    logic [7:0]  dats_q, dats_d;
    logic        valid_q, valid_d;
    logic        ferr_q, ferr_d;
    logic        tone_q, tone_d;

    logic        tone_a;
    logic [3:0]  ones_acc;
    logic        sym_last;
    logic        sym_bit;
    logic [3:0]  smp_nx;
    logic [3:0]  ones_nx;

    // Hysteresis slicer: levels between the thresholds keep the previous decision.
    always_comb begin
        tone_a = tone_q;
        if (LVs_i >= C_TH_ON) begin
            tone_a = 1'b1;
        end else if (LVs_i < C_TH_OFF) begin
            tone_a = 1'b0;
        end
        tone_d = DONE_i ? tone_a : tone_q;
    end

    // Symbol accumulation including the current sample; counters wrap to zero on close.
    always_comb begin
        ones_acc = ones_q + 4'({3'b000, tone_a});
        sym_last = (smp_q == SMP_LAST);
        sym_bit  = ({1'b0, ones_acc} << 1) > SYM_N;
        smp_nx   = sym_last ? '0 : smp_q + 4'd1;
        ones_nx  = sym_last ? '0 : ones_acc;
    end

    always_comb begin
        state_d   = state_q;
        smp_d     = smp_q;
        ones_d    = ones_q;
        bit_idx_d = bit_idx_q;
        shreg_d   = shreg_q;
        dats_d    = dats_q;
        valid_d   = 1'b0;
        ferr_d    = 1'b0;
        if (DONE_i) begin
            case (state_q)
                IDLE: begin
                    if (tone_a) begin
                        // This sample is sample 0 of the start symbol.
                        smp_d     = smp_nx;
                        ones_d    = ones_nx;
                        bit_idx_d = '0;
                        state_d   = sym_last ? (sym_bit ? DATA : IDLE) : START;
                    end
                end
                START: begin
                    smp_d  = smp_nx;
                    ones_d = ones_nx;
                    if (sym_last) begin
                        bit_idx_d = '0;
                        state_d   = sym_bit ? DATA : IDLE;
                    end
                end
                DATA: begin
                    smp_d  = smp_nx;
                    ones_d = ones_nx;
                    if (sym_last) begin
                        shreg_d = {sym_bit, shreg_q[7:1]};
                        if (bit_idx_q == 3'd7) begin
                            bit_idx_d = '0;
                            state_d   = STOP;
                        end else begin
                            bit_idx_d = bit_idx_q + 3'd1;
                        end
                    end
                end
                STOP: begin
                    smp_d  = smp_nx;
                    ones_d = ones_nx;
                    if (sym_last) begin
                        dats_d = shreg_q;
                        if (sym_bit) begin
                            ferr_d  = 1'b1;
                            state_d = WAIT_OFF;
                        end else begin
                            valid_d = 1'b1;
                            state_d = IDLE;
                        end
                    end
                end
                WAIT_OFF: begin
                    if (!tone_a) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                    smp_d   = '0;
                    ones_d  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge CK_i) begin
        if (!XARST_i) begin
            state_q   <= IDLE;
            smp_q     <= '0;
            ones_q    <= '0;
            bit_idx_q <= '0;
            shreg_q   <= '0;
            dats_q    <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
            tone_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            smp_q     <= smp_d;
            ones_q    <= ones_d;
            bit_idx_q <= bit_idx_d;
            shreg_q   <= shreg_d;
            dats_q    <= dats_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
            tone_q    <= tone_d;
        end
    end

    assign DATs_o  = dats_q;
    assign VALID_o = valid_q;
    assign FERR_o  = ferr_q;
    assign TONE_o  = tone_q;
    assign BUSY_o  = (state_q != IDLE);

endmodule

// File: tb/tb_an_rx_ook_dec.sv
// Directed and randomized checks of an_rx_ook_dec against frame-level expectations
// (intended bytes with minority sample flips) and the tone threshold rule.
module tb_an_rx_ook_dec;

    localparam logic [11:0] TH_ON  = 12'h300;
    localparam logic [11:0] TH_OFF = 12'h200;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [11:0] lvs;
    logic        done;

    logic [7:0]  dats, dats4;
    logic        valid, ferr, tone, busy;
    logic        valid4, ferr4, tone4, busy4;

    an_rx_ook_dec #(.C_SYM_LVs(5), .C_TH_ON(TH_ON), .C_TH_OFF(TH_OFF)) dut (
        .CK_i(clk), .XARST_i(rst_n), .LVs_i(lvs), .DONE_i(done),
        .DATs_o(dats), .VALID_o(valid), .FERR_o(ferr), .TONE_o(tone), .BUSY_o(busy)
    );

    an_rx_ook_dec #(.C_SYM_LVs(4), .C_TH_ON(TH_ON), .C_TH_OFF(TH_OFF)) dut4 (
        .CK_i(clk), .XARST_i(rst_n), .LVs_i(lvs), .DONE_i(done),
        .DATs_o(dats4), .VALID_o(valid4), .FERR_o(ferr4), .TONE_o(tone4), .BUSY_o(busy4)
    );

    always #5 clk = ~clk;

    int          n_chk = 0;
    int          n_pass = 0;
    int          n_valid = 0;
    int          n_ferr = 0;
    int          n_both = 0;
    int          n_valid4 = 0;
    logic [7:0]  last_dat = '0;
    logic [7:0]  last_dat4 = '0;
    logic        tone_m = 1'b0;
    bit          rnd_lv = 1'b0;
    int          gap_max = 0;

    int          v0, f0, v4;
    logic [7:0]  byte_r;
    logic [14:0] pat;

    // Pulse monitor, sampled just after each rising edge.
    always @(posedge clk) begin
        #1;
        if (valid) begin
            n_valid++;
            last_dat = dats;
        end
        if (ferr) n_ferr++;
        if (valid && ferr) n_both++;
        if (valid4) begin
            n_valid4++;
            last_dat4 = dats4;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic logic [11:0] lv_of(input bit t);
        if (rnd_lv)
            return t ? 12'($urandom_range(32'(TH_ON), 4095)) : 12'($urandom_range(0, 32'(TH_OFF) - 1));
        return t ? 12'h400 : 12'h050;
    endfunction

    // One strobe at the current falling edge, then 'gap' idle cycles.
    task automatic strobe(input logic [11:0] lv, input int gap);
        done = 1'b1;
        lvs  = lv;
        if (lv >= TH_ON) tone_m = 1'b1;
        else if (lv < TH_OFF) tone_m = 1'b0;
        @(negedge clk);
        chk("tone", 32'(tone), 32'(tone_m));
        done = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic send_sym(input logic [14:0] p, input int n);
        for (int i = 0; i < n; i++)
            strobe(lv_of(p[i]), int'($urandom_range(0, 32'(gap_max))));
    endtask

    task automatic send_frame(input logic [7:0] b, input bit stop_tone, input int n);
        send_sym('1, n);
        for (int i = 0; i < 8; i++) send_sym(b[i] ? '1 : '0, n);
        send_sym(stop_tone ? '1 : '0, n);
    endtask

    // Symbol pattern with up to two minority flips; start sample 0 is never flipped.
    function automatic logic [14:0] mk_pat(input bit b, input int n, input bit is_start);
        logic [14:0] p;
        int unsigned k, pos;
        p = b ? '1 : '0;
        k = $urandom_range(0, 2);
        for (int unsigned j = 0; j < k; j++) begin
            pos = is_start ? $urandom_range(1, 32'(n) - 1) : $urandom_range(0, 32'(n) - 1);
            p[pos] = ~p[pos];
        end
        return p;
    endfunction

    task automatic do_reset();
        rst_n  = 1'b0;
        done   = 1'b0;
        repeat (2) @(negedge clk);
        rst_n  = 1'b1;
        tone_m = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        done  = 1'b0;
        lvs   = '0;
        repeat (3) @(negedge clk);
        chk("rst_dats",  32'(dats),  32'h00);
        chk("rst_valid", 32'(valid), 0);
        chk("rst_ferr",  32'(ferr),  0);
        chk("rst_tone",  32'(tone),  0);
        chk("rst_busy",  32'(busy),  0);
        rst_n = 1'b1;
        @(negedge clk);

        // Hysteresis; the sequence also forms a rejected start glitch.
        v0 = n_valid; f0 = n_ferr;
        strobe(12'h300, 0); chk("hyst0", 32'(tone), 1);
        strobe(12'h250, 0); chk("hyst1", 32'(tone), 1);
        strobe(12'h1FF, 0); chk("hyst2", 32'(tone), 0);
        strobe(12'h250, 0); chk("hyst3", 32'(tone), 0);
        chk("hyst_busy_mid", 32'(busy), 1);
        strobe(12'h050, 0);
        chk("hyst_busy_end", 32'(busy), 0);

        // 0xA5 with back-to-back strobes: pulse one clock after the 50th strobe.
        gap_max = 0;
        send_sym('1, 5);
        for (int i = 0; i < 8; i++) send_sym((8'hA5 >> i) & 8'h01 ? '1 : '0, 5);
        send_sym('0, 4);
        chk("lat_pre_valid", 32'(valid), 0);
        chk("lat_pre_busy",  32'(busy),  1);
        strobe(lv_of(1'b0), 0);
        chk("lat_valid", 32'(valid), 1);
        chk("lat_dats",  32'(dats),  32'hA5);
        chk("lat_ferr",  32'(ferr),  0);
        @(negedge clk);
        chk("lat_valid_1cyc", 32'(valid), 0);
        chk("lat_cnt", 32'(n_valid - v0), 1);
        chk("lat_fcnt", 32'(n_ferr - f0), 0);
        chk("lat_hold", 32'(dats), 32'hA5);

        // Start glitch 1,0,0,0,0.
        v0 = n_valid; f0 = n_ferr;
        gap_max = 1;
        send_sym(15'b000_0000_0000_0001, 4);
        chk("glitch_busy4", 32'(busy), 1);
        strobe(lv_of(1'b0), 1);
        chk("glitch_busy5", 32'(busy), 0);
        chk("glitch_pulses", 32'(n_valid - v0 + n_ferr - f0), 0);

        // Framing error on 0x3C, WAIT_OFF, then 0x81.
        v0 = n_valid; f0 = n_ferr;
        send_frame(8'h3C, 1'b1, 5);
        chk("ferr_cnt",  32'(n_ferr - f0), 1);
        chk("ferr_nval", 32'(n_valid - v0), 0);
        chk("ferr_dats", 32'(dats), 32'h3C);
        send_sym('1, 3);
        chk("waitoff_busy", 32'(busy), 1);
        strobe(lv_of(1'b0), 1);
        chk("waitoff_exit", 32'(busy), 0);
        send_frame(8'h81, 1'b0, 5);
        strobe(lv_of(1'b0), 1);
        chk("after_ferr_valid", 32'(n_valid - v0), 1);
        chk("after_ferr_dats",  32'(last_dat), 32'h81);

        // Majority: 1,1,0,0,1 -> 1 and 1,1,0,0,0 -> 0.
        v0 = n_valid;
        send_sym('1, 5);
        send_sym(15'b000_0000_0001_0011, 5);
        send_sym(15'b000_0000_0000_0011, 5);
        for (int i = 2; i < 8; i++) send_sym((8'hA4 >> i) & 8'h01 ? '1 : '0, 5);
        send_sym('0, 5);
        strobe(lv_of(1'b0), 0);
        chk("maj_valid", 32'(n_valid - v0), 1);
        chk("maj_dats",  32'(dats), 32'hA5);

        // Reset during bit 4 of 0xFF.
        v0 = n_valid; f0 = n_ferr;
        send_sym('1, 5);
        for (int i = 0; i < 4; i++) send_sym('1, 5);
        send_sym('1, 2);
        do_reset();
        chk("mrst_dats",  32'(dats),  32'h00);
        chk("mrst_busy",  32'(busy),  0);
        chk("mrst_tone",  32'(tone),  0);
        chk("mrst_valid", 32'(valid), 0);
        chk("mrst_nopulse", 32'(n_valid - v0 + n_ferr - f0), 0);
        send_frame(8'h12, 1'b0, 5);
        strobe(lv_of(1'b0), 0);
        chk("mrst_next_valid", 32'(n_valid - v0), 1);
        chk("mrst_next_dats",  32'(last_dat), 32'h12);

        // Four samples per symbol: a 2-of-4 tie decodes as 0.
        do_reset();
        v4 = n_valid4;
        send_sym('1, 4);
        send_sym(15'b000_0000_0000_0011, 4);
        for (int i = 1; i < 8; i++) send_sym((8'h81 >> i) & 8'h01 ? '1 : '0, 4);
        send_sym('0, 4);
        strobe(lv_of(1'b0), 0);
        chk("tie4_valid", 32'(n_valid4 - v4), 1);
        chk("tie4_dats",  32'(dats4), 32'h80);
        do_reset();

        // Randomized frames with minority flips, random levels and strobe spacing.
        rnd_lv  = 1'b1;
        gap_max = 2;
        for (int f = 0; f < 20; f++) begin
            v0 = n_valid; f0 = n_ferr;
            byte_r = 8'($urandom);
            send_sym(mk_pat(1'b1, 5, 1'b1), 5);
            for (int i = 0; i < 8; i++) send_sym(mk_pat(byte_r[i], 5, 1'b0), 5);
            send_sym(mk_pat(1'b0, 5, 1'b0), 5);
            strobe(lv_of(1'b0), 1);
            strobe(lv_of(1'b0), 0);
            chk("rnd_valid", 32'(n_valid - v0), 1);
            chk("rnd_ferr",  32'(n_ferr - f0), 0);
            chk("rnd_dats",  32'(dats), 32'(byte_r));
        end

        chk("no_overlap", 32'(n_both), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
